mitchell_antilog_pipe: RTL and testbench

MITCHELL_ANTILOG_PIPE -- requirements
Module: mitchell_antilog_pipe

---
 rtl/mitchell_pkg.sv | 13 +
 rtl/mitchell_antilog.sv | 15 +
 rtl/mitchell_antilog_pipe.sv | 53 +++++
 tb/tb_mitchell_antilog_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mitchell_pkg.sv
// mitchell_pkg: shared widths and the stage-1 record for the Mitchell log/antilog blocks
package mitchell_pkg;
  localparam int LOG_W  = 10;
  localparam int PROD_W = 16;
  localparam int CHAR_W = 3;
  localparam int MANT_W = 7;
  localparam int K_W    = CHAR_W + 1;
  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [MANT_W-1:0] f;
    logic              z;
  } s1_t;
endpackage

// File: rtl/mitchell_antilog.sv
// mitchell_antilog: combinational antilog, p = z ? 0 : ({1,f} << k) >> 7, fraction truncated
module mitchell_antilog
  import mitchell_pkg::*;
#(
  parameter int PROD_W = mitchell_pkg::PROD_W
) (
  input  logic [K_W-1:0]    k,
  input  logic [MANT_W-1:0] f,
  input  logic              z,
  output logic [PROD_W-1:0] p
);
  logic [PROD_W+MANT_W-1:0] sh;
  assign sh = {{(PROD_W-1){1'b0}}, 1'b1, f} << k;
  assign p  = z ? '0 : sh[PROD_W+MANT_W-1:MANT_W];
endmodule

// File: rtl/mitchell_antilog_pipe.sv
// mitchell_antilog_pipe: two-stage valid/ready pipeline multiplying two Mitchell log codes
module mitchell_antilog_pipe #(
  parameter int LOG_W  = mitchell_pkg::LOG_W,
  parameter int PROD_W = mitchell_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOG_W-1:0]  la,
  input  logic [LOG_W-1:0]  lb,
  input  logic              za,
  input  logic              zb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p
);
  import mitchell_pkg::*;
  s1_t               s1, s1_nxt;
  logic              s1_valid, out_adv;
  logic [MANT_W:0]   fs;
  logic [PROD_W-1:0] res;
  assign out_adv  = !out_valid || out_ready;
  assign in_ready = !s1_valid || out_adv;
  assign fs       = {1'b0, la[MANT_W-1:0]} + {1'b0, lb[MANT_W-1:0]};
  // mantissa carry bumps the characteristic sum
  assign s1_nxt.k = K_W'(la[MANT_W +: CHAR_W]) + K_W'(lb[MANT_W +: CHAR_W]) + K_W'(fs[MANT_W]);
  assign s1_nxt.f = fs[MANT_W-1:0];
  assign s1_nxt.z = za | zb;
  mitchell_antilog #(.PROD_W(PROD_W)) u_antilog (
    .k(s1.k),
    .f(s1.f),
    .z(s1.z),
    .p(res)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= s1_nxt;
      end
      if (out_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) p <= res;
      end
    end
  end
endmodule

// File: tb/tb_mitchell_antilog_pipe.sv
// tb_mitchell_antilog_pipe: table vectors, random streaming, backpressure and reset checks
module tb_mitchell_antilog_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, za, zb;
  logic [9:0]  la, lb;
  logic        in_ready, out_valid;
  logic [15:0] p;
  always #5 clk = ~clk;
  mitchell_antilog_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .la(la), .lb(lb), .za(za), .zb(zb),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );
  typedef struct {logic [15:0] exp; int cyc; bit lat;} exp_t;
  typedef struct {logic [9:0] la, lb; logic za, zb; logic [15:0] exp;} vec_t;
  exp_t        q[$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  int          out_cnt, first_out, last_out;
  bit          acc, cur_lat;
  logic [15:0] cur_exp;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // x in 1..255 -> characteristic floor(log2 x), 7-bit truncated fractional part
  function automatic logic [9:0] enc(int x);
    int k = 0;
    int m;
    while ((x >> (k + 1)) != 0) k++;
    m = ((x - (1 << k)) << 7) >> k;
    return {k[2:0], m[6:0]};
  endfunction
  // add logs as fixed-point values in 1/128 units, then take 2^sum with truncation
  function automatic logic [15:0] ref_p(logic [9:0] a, logic [9:0] b, logic a0, logic b0);
    int s = int'(a[9:7]) * 128 + int'(a[6:0]) + int'(b[9:7]) * 128 + int'(b[6:0]);
    int v = ((128 + s % 128) << (s / 128)) / 128;
    return (a0 || b0) ? 16'd0 : v[15:0];
  endfunction
  // called just after a negedge with inputs driven; evaluates handshakes, moves to next negedge
  task automatic step();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        check("p", p, e.exp);
        if (e.lat) check("latency", cyc - e.cyc, 2);
        if (out_cnt == 0) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
    end
    if (acc) q.push_back('{exp: cur_exp, cyc: cyc, lat: cur_lat});
    cyc++;
    @(negedge clk);
  endtask
  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check("drain_left", q.size(), 0);
  endtask
  task automatic rand_op();
    int x = $urandom_range(0, 255);
    int y = $urandom_range(0, 255);
    za = (x == 0);
    zb = (y == 0);
    la = za ? 10'($urandom) : enc(x);
    lb = zb ? 10'($urandom) : enc(y);
    cur_exp = ref_p(la, lb, za, zb);
  endtask
  vec_t vt[8];
  int   n_acc;
  initial begin
    vt[0] = '{10'h0C0, 10'h0C0, 1'b0, 1'b0, 16'd8};
    vt[1] = '{10'h3FF, 10'h3FF, 1'b0, 1'b0, 16'd65024};
    vt[2] = '{10'h000, 10'h000, 1'b0, 1'b0, 16'd1};
    vt[3] = '{10'h000, 10'h000, 1'b1, 1'b0, 16'd0};
    vt[4] = '{10'h3FF, 10'h3FF, 1'b0, 1'b1, 16'd0};
    vt[5] = '{10'h080, 10'h080, 1'b0, 1'b0, 16'd4};
    vt[6] = '{10'h080, 10'h0C0, 1'b0, 1'b0, 16'd6};
    vt[7] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 16'd255};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    la = '0; lb = '0; za = 1'b0; zb = 1'b0; cur_lat = 1'b0; cur_exp = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    // directed table, one transaction at a time
    foreach (vt[i]) begin
      la = vt[i].la; lb = vt[i].lb; za = vt[i].za; zb = vt[i].zb;
      cur_exp = vt[i].exp; cur_lat = 1'b1; in_valid = 1'b1;
      step();
      check("tbl_accept", acc, 1);
      drain();
    end
    // back-to-back random streaming
    out_cnt = 0; n_acc = 0; cur_lat = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      rand_op();
      step();
      n_acc += int'(acc);
    end
    drain();
    check("stream_accepts", n_acc, 255);
    check("stream_outputs", out_cnt, 255);
    check("stream_span", last_out - first_out, 254);
    // backpressure: five stalled cycles with input offered
    cur_lat = 1'b0; out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    rand_op();
    for (int i = 0; i < 5; i++) begin
      step();
      if (acc) begin
        n_acc++;
        rand_op();
      end
      if (i >= 2) begin
        check("bp_out_valid", out_valid, 1);
        check("bp_p_hold", p, q[0].exp);
      end
    end
    check("bp_accepts", n_acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("bp_third_accept", acc, 1);
    drain();
    // reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    rand_op(); step();
    rand_op(); step();
    check("pre_rst_full", {out_valid, in_ready}, 2'b10);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_p", p, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_out_valid", out_valid, 0);
    la = 10'h0C0; lb = 10'h0C0; za = 1'b0; zb = 1'b0;
    cur_exp = 16'd8; cur_lat = 1'b1; in_valid = 1'b1;
    step();
    check("post_rst_accept", acc, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
